// File: rtl/chip_word_encoder_pkg.sv
// chip_word_encoder_pkg: trigger-word encoding shared by the encoder and the output stage
package chip_word_encoder_pkg;
  typedef logic [15:0] word_t;
  localparam word_t TRIG_IDLE = 16'hAAAA;
  function automatic word_t trig_code(input logic [3:0] p);
    word_t w;
    w = TRIG_IDLE;
    w[{p[3:2], 2'b00} +: 4] = 4'h1 << p[1:0];
    return w;
  endfunction
  function automatic logic is_trig_code(input word_t w);
    logic hit;
    hit = 1'b0;
    for (int i = 1; i < 16; i++) hit |= (w == trig_code(4'(i)));
    return hit;
  endfunction
endpackage

// File: rtl/chip_word_encoder_if.sv
// chip_word_encoder_if: host command handshake and downstream word FIFO write side
interface chip_word_encoder_if;
  import chip_word_encoder_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  word_t cmd_data;
  logic out_full;
  logic word_valid;
  word_t data_out;
  modport master(output cmd_valid, cmd_data, out_full, input cmd_ready, word_valid, data_out);
  modport slave(input cmd_valid, cmd_data, out_full, output cmd_ready, word_valid, data_out);
endinterface

// File: rtl/chip_word_encoder_sync_fifo.sv
// chip_word_encoder_sync_fifo: single-clock FIFO, wrap-bit pointers, no write-through
module chip_word_encoder_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk160,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk160)
    if (wr) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk160)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(wr);
      rp <= rp + (AW+1)'(rd);
    end
endmodule

// File: rtl/chip_word_encoder.sv
// chip_word_encoder: packs per-BX trigger bits into 4-BX patterns, encodes them as trigger
// words and merges them ahead of host commands into the downstream word FIFO.
module chip_word_encoder
  import chip_word_encoder_pkg::*;
#(
  parameter int CMD_DEPTH = 8,
  parameter int CNT_W     = 8
) (
  input  logic              clk160,
  input  logic              rst_n,
  input  logic              bx_strobe,
  input  logic              bx_sync,
  input  logic              trig_in,
  chip_word_encoder_if.slave bus,
  output logic              trig_overflow,
  output logic              cmd_reject,
  output logic [CNT_W-1:0]  drop_cnt
);
  logic [1:0] slot, cur_slot;
  logic [3:0] pat, new_pat;
  logic tb_vld, complete, load, drop, emit_trig, pop_cmd, accept, is_trig;
  logic fifo_full, fifo_empty;
  word_t tb_word, fifo_dout;
  always_comb begin
    cur_slot = bx_sync ? 2'd0 : slot;
    new_pat = bx_sync ? 4'd0 : pat;
    new_pat[~cur_slot] = trig_in;
    complete = bx_strobe && cur_slot == 2'd3 && new_pat != 4'd0;
    emit_trig = !bus.out_full && tb_vld;
    pop_cmd = !bus.out_full && !tb_vld && !fifo_empty;
    // a full buffer can still take the new word if it drains this same cycle
    load = complete && (!tb_vld || emit_trig);
    drop = complete && tb_vld && !emit_trig;
    accept = bus.cmd_valid && bus.cmd_ready;
    is_trig = is_trig_code(bus.cmd_data);
  end
  assign bus.cmd_ready = !fifo_full;
  chip_word_encoder_sync_fifo #(.WIDTH(16), .DEPTH(CMD_DEPTH)) u_fifo (
    .clk160(clk160),
    .rst_n(rst_n),
    .push(accept && !is_trig),
    .pop(pop_cmd),
    .din(bus.cmd_data),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  always_ff @(posedge clk160)
    if (!rst_n) begin
      slot <= 2'd0;
      pat <= 4'd0;
      tb_vld <= 1'b0;
      tb_word <= '0;
      trig_overflow <= 1'b0;
      drop_cnt <= '0;
      cmd_reject <= 1'b0;
      bus.word_valid <= 1'b0;
      bus.data_out <= '0;
    end else begin
      if (bx_strobe) begin
        slot <= cur_slot + 2'd1;
        pat <= cur_slot == 2'd3 ? 4'd0 : new_pat;
      end
      tb_vld <= load || (tb_vld && !emit_trig);
      if (load) tb_word <= trig_code(new_pat);
      if (drop) begin
        trig_overflow <= 1'b1;
        drop_cnt <= drop_cnt + CNT_W'(drop_cnt != '1);
      end
      cmd_reject <= accept && is_trig;
      bus.word_valid <= emit_trig || pop_cmd;
      if (emit_trig || pop_cmd) bus.data_out <= emit_trig ? tb_word : fifo_dout;
    end
endmodule

// File: tb/tb_chip_word_encoder.sv
// tb_chip_word_encoder: scoreboard bench; expected words queued at stimulus, popped on word_valid
module tb_chip_word_encoder;
  logic clk160 = 1'b0;
  logic rst_n = 1'b0;
  logic bx_strobe = 1'b0;
  logic bx_sync = 1'b0;
  logic trig_in = 1'b0;
  logic trig_overflow, cmd_reject;
  logic [7:0] drop_cnt;
  int n_chk = 0;
  int n_pass = 0;
  int rej_cnt = 0;
  logic [15:0] exp_q [$];
  localparam logic [15:0] CODES [16] = '{
    16'hAAAA, 16'hAAA2, 16'hAAA4, 16'hAAA8, 16'hAA1A, 16'hAA2A, 16'hAA4A, 16'hAA8A,
    16'hA1AA, 16'hA2AA, 16'hA4AA, 16'hA8AA, 16'h1AAA, 16'h2AAA, 16'h4AAA, 16'h8AAA};
  chip_word_encoder_if bus();
  chip_word_encoder #(.CMD_DEPTH(8), .CNT_W(8)) dut (
    .clk160(clk160),
    .rst_n(rst_n),
    .bx_strobe(bx_strobe),
    .bx_sync(bx_sync),
    .trig_in(trig_in),
    .bus(bus.slave),
    .trig_overflow(trig_overflow),
    .cmd_reject(cmd_reject),
    .drop_cnt(drop_cnt)
  );
  always #5 clk160 = ~clk160;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk160) begin
    if (rst_n && bus.word_valid) begin
      if (exp_q.size() == 0) chk("spurious_word", 32'(bus.data_out), 32'hFFFF_FFFF);
      else chk("word", 32'(bus.data_out), 32'(exp_q.pop_front()));
    end
    if (cmd_reject) rej_cnt++;
  end
  task automatic tick();
    @(posedge clk160);
    #1;
  endtask
  task automatic bx(input logic t, input logic s);
    bx_strobe = 1'b1;
    trig_in = t;
    bx_sync = s;
    tick();
    bx_strobe = 1'b0;
    bx_sync = 1'b0;
    trig_in = 1'b0;
    repeat (3) tick();
  endtask
  task automatic window(input logic [3:0] p, input bit ex);
    if (p != 4'd0 && ex) exp_q.push_back(CODES[p]);
    for (int k = 0; k < 4; k++) bx(p[3-k], k == 0);
  endtask
  task automatic cmd(input logic [15:0] w);
    bus.cmd_valid = 1'b1;
    bus.cmd_data = w;
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    chk("drain", 32'(exp_q.size()), 0);
  endtask
  initial begin
    int r0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data = '0;
    bus.out_full = 1'b0;
    repeat (2) tick();
    chk("rst_word_valid", 32'(bus.word_valid), 0);
    chk("rst_data_out", 32'(bus.data_out), 0);
    chk("rst_overflow", 32'(trig_overflow), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    chk("rst_reject", 32'(cmd_reject), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    // single pattern 1000 with exact latency
    exp_q.push_back(CODES[8]);
    bx(1'b1, 1'b1);
    bx(1'b0, 1'b0);
    bx(1'b0, 1'b0);
    bx_strobe = 1'b1;
    tick();
    bx_strobe = 1'b0;
    chk("lat_cycle1", 32'(bus.word_valid), 0);
    tick();
    chk("lat_cycle2", 32'(bus.word_valid), 1);
    drain();
    for (int p = 0; p < 16; p++) window(4'(p), 1'b1);
    drain();
    // buffer held by out_full: first word kept, second dropped
    bus.out_full = 1'b1;
    window(4'd5, 1'b1);
    window(4'd9, 1'b0);
    chk("overflow", 32'(trig_overflow), 1);
    chk("drop_cnt", 32'(drop_cnt), 1);
    bus.out_full = 1'b0;
    drain();
    bus.out_full = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cmd(16'(i));
      exp_q.push_back(16'(i));
      chk("fill_ready", 32'(bus.cmd_ready), 32'(i < 8));
    end
    repeat (3) tick();
    chk("full_no_output", 32'(exp_q.size()), 8);
    bus.out_full = 1'b0;
    drain();
    chk("ready_back", 32'(bus.cmd_ready), 1);
    r0 = rej_cnt;
    cmd(16'hAA4A);
    repeat (3) tick();
    chk("reject_pulses", 32'(rej_cnt - r0), 1);
    exp_q.push_back(16'h1234);
    cmd(16'h1234);
    drain();
    chk("idle_not_rejected", 32'(rej_cnt - r0), 1);
    // trigger outranks an earlier queued command
    bus.out_full = 1'b1;
    cmd(16'h5555);
    window(4'd3, 1'b1);
    exp_q.push_back(16'h5555);
    bus.out_full = 1'b0;
    drain();
    bus.out_full = 1'b1;
    cmd(16'h0101);
    cmd(16'h0202);
    bx(1'b1, 1'b1);
    bx(1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_word_valid", 32'(bus.word_valid), 0);
    chk("mid_rst_data_out", 32'(bus.data_out), 0);
    chk("mid_rst_drop_cnt", 32'(drop_cnt), 0);
    chk("mid_rst_overflow", 32'(trig_overflow), 0);
    rst_n = 1'b1;
    bus.out_full = 1'b0;
    tick();
    chk("mid_rst_ready", 32'(bus.cmd_ready), 1);
    bx(1'b0, 1'b0);
    bx(1'b0, 1'b0);
    repeat (10) tick();
    chk("post_rst_silent", 32'(bus.data_out), 0);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
